// File: rtl/issue_queue_pkg.sv
// Shared types and sizing for the issue queue and the register-read stage it feeds.
package issue_queue_pkg;

  localparam int NUM_PHYS_REGS = 64;
  localparam int LOG_PHYS      = $clog2(NUM_PHYS_REGS);
  localparam int IQ_DEPTH      = 8;
  localparam int PAYLOAD_W     = 32;
  localparam int IDX_W         = $clog2(IQ_DEPTH);
  localparam int CNT_W         = IDX_W + 1;

  typedef logic [LOG_PHYS-1:0] phys_tag_t;

  typedef struct packed {
    logic                 valid;
    phys_tag_t            srcA;
    logic                 rdyA;
    phys_tag_t            srcB;
    logic                 rdyB;
    phys_tag_t            dest;
    logic [PAYLOAD_W-1:0] payload;
  } iq_entry_t;

  typedef struct packed {
    phys_tag_t            srcA;
    phys_tag_t            srcB;
    phys_tag_t            dest;
    logic [PAYLOAD_W-1:0] payload;
  } issue_bundle_t;

  function automatic logic tagHit(input logic wakeValid, input phys_tag_t wakeTag,
                                  input phys_tag_t src);
    return wakeValid && (src == wakeTag);
  endfunction

endpackage

// File: rtl/issue_queue_if.sv
// Dispatch, wakeup and issue signals between rename, writeback, the issue queue and register read.
interface issue_queue_if;
  import issue_queue_pkg::*;

  logic                 Flush;
  logic                 Dispatch_Valid;
  logic                 Dispatch_Ready;
  phys_tag_t            Dispatch_SrcA;
  logic                 Dispatch_SrcA_Rdy;
  phys_tag_t            Dispatch_SrcB;
  logic                 Dispatch_SrcB_Rdy;
  phys_tag_t            Dispatch_Dest;
  logic [PAYLOAD_W-1:0] Dispatch_Payload;
  logic                 Wake_Valid;
  phys_tag_t            Wake_Tag;
  logic                 Issue_Stall;
  logic                 Issue_Valid;
  phys_tag_t            Issue_SrcA;
  phys_tag_t            Issue_SrcB;
  phys_tag_t            Issue_Dest;
  logic [PAYLOAD_W-1:0] Issue_Payload;
  logic [CNT_W-1:0]     Count;

  modport slave (
    input  Flush, Dispatch_Valid, Dispatch_SrcA, Dispatch_SrcA_Rdy, Dispatch_SrcB,
           Dispatch_SrcB_Rdy, Dispatch_Dest, Dispatch_Payload, Wake_Valid, Wake_Tag,
           Issue_Stall,
    output Dispatch_Ready, Issue_Valid, Issue_SrcA, Issue_SrcB, Issue_Dest, Issue_Payload,
           Count
  );

  modport master (
    output Flush, Dispatch_Valid, Dispatch_SrcA, Dispatch_SrcA_Rdy, Dispatch_SrcB,
           Dispatch_SrcB_Rdy, Dispatch_Dest, Dispatch_Payload, Wake_Valid, Wake_Tag,
           Issue_Stall,
    input  Dispatch_Ready, Issue_Valid, Issue_SrcA, Issue_SrcB, Issue_Dest, Issue_Payload,
           Count
  );

endinterface

// File: rtl/issue_queue_select.sv
// Oldest-first picker: lowest-index ready entry wins, since entry 0 is always the oldest.
module iq_select
  import issue_queue_pkg::*;
(
  input  logic [IQ_DEPTH-1:0] candidate,
  output logic [IQ_DEPTH-1:0] grant,
  output logic [IDX_W-1:0]    grantIdx,
  output logic                anyReady
);

  assign anyReady = |candidate;

  always_comb begin
    logic found;
    found    = 1'b0;
    grant    = '0;
    grantIdx = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      if (candidate[i] && !found) begin
        grant[i] = 1'b1;
        grantIdx = IDX_W'(i);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Collapsing out-of-order issue queue: wakeup tracking, oldest-ready select and a registered
// issue slot whose source tags address the register-read ports.
module issue_queue
  import issue_queue_pkg::*;
(
  input  logic          CLK,
  input  logic          RESET,
  issue_queue_if.slave  iq
);

  iq_entry_t           entryReg  [IQ_DEPTH];
  iq_entry_t           entryNext [IQ_DEPTH];
  iq_entry_t           wokeEntry [IQ_DEPTH];
  iq_entry_t           dispatchEntry;
  logic [CNT_W-1:0]    countReg, countNext, appendIdx;
  logic                issueValidReg, issueValidNext;
  issue_bundle_t       issueReg, issueNext;
  logic [IQ_DEPTH-1:0] candidate, grant;
  logic [IDX_W-1:0]    grantIdx;
  logic                anyReady, dispatchReady, dispatchFire, doIssue;

  // Ready bits are the registered ones, so a wakeup takes effect for select one cycle later.
  generate
    for (genvar gi = 0; gi < IQ_DEPTH; gi++) begin : gCand
      assign candidate[gi] = entryReg[gi].valid & entryReg[gi].rdyA & entryReg[gi].rdyB;
    end
  endgenerate

  iq_select uSelect (
    .candidate (candidate),
    .grant     (grant),
    .grantIdx  (grantIdx),
    .anyReady  (anyReady)
  );

  assign dispatchReady = (countReg < CNT_W'(IQ_DEPTH));
  assign dispatchFire  = iq.Dispatch_Valid && dispatchReady;
  assign doIssue       = !iq.Issue_Stall && anyReady;
  assign appendIdx     = countReg - CNT_W'(doIssue);

  always_comb begin
    for (int i = 0; i < IQ_DEPTH; i++) begin
      wokeEntry[i] = entryReg[i];
      if (entryReg[i].valid && tagHit(iq.Wake_Valid, iq.Wake_Tag, entryReg[i].srcA))
        wokeEntry[i].rdyA = 1'b1;
      if (entryReg[i].valid && tagHit(iq.Wake_Valid, iq.Wake_Tag, entryReg[i].srcB))
        wokeEntry[i].rdyB = 1'b1;
    end
  end

  always_comb begin
    dispatchEntry         = '0;
    dispatchEntry.valid   = 1'b1;
    dispatchEntry.srcA    = iq.Dispatch_SrcA;
    dispatchEntry.srcB    = iq.Dispatch_SrcB;
    dispatchEntry.dest    = iq.Dispatch_Dest;
    dispatchEntry.payload = iq.Dispatch_Payload;
    dispatchEntry.rdyA    = iq.Dispatch_SrcA_Rdy ||
                            tagHit(iq.Wake_Valid, iq.Wake_Tag, iq.Dispatch_SrcA);
    dispatchEntry.rdyB    = iq.Dispatch_SrcB_Rdy ||
                            tagHit(iq.Wake_Valid, iq.Wake_Tag, iq.Dispatch_SrcB);
  end

  // Shift, append and wakeup all act on the same pre-edge snapshot.
  always_comb begin
    for (int i = 0; i < IQ_DEPTH; i++)
      entryNext[i] = wokeEntry[i];
    if (doIssue) begin
      for (int i = 0; i < IQ_DEPTH - 1; i++) begin
        if (IDX_W'(i) >= grantIdx)
          entryNext[i] = wokeEntry[i + 1];
      end
      entryNext[IQ_DEPTH-1] = '0;
    end
    if (dispatchFire)
      entryNext[appendIdx[IDX_W-1:0]] = dispatchEntry;
    if (iq.Flush) begin
      for (int i = 0; i < IQ_DEPTH; i++)
        entryNext[i] = '0;
    end
  end

  always_comb begin
    countNext = countReg + CNT_W'(dispatchFire) - CNT_W'(doIssue);
    if (iq.Flush)
      countNext = '0;
  end

  always_comb begin
    issueNext      = issueReg;
    issueValidNext = issueValidReg;
    if (iq.Flush) begin
      issueValidNext = 1'b0;
    end else if (!iq.Issue_Stall) begin
      issueValidNext = anyReady;
      if (anyReady) begin
        issueNext.srcA    = entryReg[grantIdx].srcA;
        issueNext.srcB    = entryReg[grantIdx].srcB;
        issueNext.dest    = entryReg[grantIdx].dest;
        issueNext.payload = entryReg[grantIdx].payload;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < IQ_DEPTH; i++)
        entryReg[i] <= '0;
      countReg      <= '0;
      issueValidReg <= 1'b0;
      issueReg      <= '0;
    end else begin
      for (int i = 0; i < IQ_DEPTH; i++)
        entryReg[i] <= entryNext[i];
      countReg      <= countNext;
      issueValidReg <= issueValidNext;
      issueReg      <= issueNext;
    end
  end

  assign iq.Dispatch_Ready = dispatchReady;
  assign iq.Issue_Valid    = issueValidReg;
  assign iq.Issue_SrcA     = issueReg.srcA;
  assign iq.Issue_SrcB     = issueReg.srcB;
  assign iq.Issue_Dest     = issueReg.dest;
  assign iq.Issue_Payload  = issueReg.payload;
  assign iq.Count          = countReg;

endmodule

// File: tb/tb_issue_queue.sv
// Directed scenarios plus a randomized run against an age-ordered queue model of the issue stage.
module tb_issue_queue;
  import issue_queue_pkg::*;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  issue_queue_if iqIf ();

  issue_queue dut (
    .CLK   (CLK),
    .RESET (RESET),
    .iq    (iqIf)
  );

  typedef struct {
    phys_tag_t            srcA;
    bit                   rdyA;
    phys_tag_t            srcB;
    bit                   rdyB;
    phys_tag_t            dest;
    logic [PAYLOAD_W-1:0] payload;
  } m_ent_t;

  m_ent_t               mQ[$];
  bit                   mIssValid;
  phys_tag_t            mIssA, mIssB, mIssD;
  logic [PAYLOAD_W-1:0] mIssP;

  int checks = 0;
  int errors = 0;

  task automatic modelReset();
    mQ.delete();
    mIssValid = 0;
    mIssA = '0; mIssB = '0; mIssD = '0; mIssP = '0;
  endtask

  // One clock of the model: oldest ready leaves, wakeups land, new arrival joins the tail.
  task automatic modelStep();
    int w;
    bit acc;
    m_ent_t e;
    if (iqIf.Flush) begin
      mQ.delete();
      mIssValid = 0;
      return;
    end
    acc = iqIf.Dispatch_Valid && (mQ.size() < IQ_DEPTH);
    if (!iqIf.Issue_Stall) begin
      w = -1;
      foreach (mQ[i]) if (w < 0 && mQ[i].rdyA && mQ[i].rdyB) w = i;
      if (w >= 0) begin
        mIssValid = 1;
        mIssA = mQ[w].srcA; mIssB = mQ[w].srcB; mIssD = mQ[w].dest; mIssP = mQ[w].payload;
        mQ.delete(w);
      end else begin
        mIssValid = 0;
      end
    end
    if (iqIf.Wake_Valid) begin
      foreach (mQ[i]) begin
        if (mQ[i].srcA == iqIf.Wake_Tag) mQ[i].rdyA = 1;
        if (mQ[i].srcB == iqIf.Wake_Tag) mQ[i].rdyB = 1;
      end
    end
    if (acc) begin
      e.srcA    = iqIf.Dispatch_SrcA;
      e.srcB    = iqIf.Dispatch_SrcB;
      e.dest    = iqIf.Dispatch_Dest;
      e.payload = iqIf.Dispatch_Payload;
      e.rdyA    = iqIf.Dispatch_SrcA_Rdy || (iqIf.Wake_Valid && iqIf.Dispatch_SrcA == iqIf.Wake_Tag);
      e.rdyB    = iqIf.Dispatch_SrcB_Rdy || (iqIf.Wake_Valid && iqIf.Dispatch_SrcB == iqIf.Wake_Tag);
      mQ.push_back(e);
    end
  endtask

  task automatic tick();
    modelStep();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic setIdle();
    iqIf.Flush = 0; iqIf.Dispatch_Valid = 0;
    iqIf.Dispatch_SrcA = '0; iqIf.Dispatch_SrcA_Rdy = 0;
    iqIf.Dispatch_SrcB = '0; iqIf.Dispatch_SrcB_Rdy = 0;
    iqIf.Dispatch_Dest = '0; iqIf.Dispatch_Payload = '0;
    iqIf.Wake_Valid = 0; iqIf.Wake_Tag = '0; iqIf.Issue_Stall = 0;
  endtask

  task automatic setDispatch(input int a, input bit ar, input int b, input bit br,
                             input int d, input logic [PAYLOAD_W-1:0] p);
    iqIf.Dispatch_Valid = 1;
    iqIf.Dispatch_SrcA = phys_tag_t'(a); iqIf.Dispatch_SrcA_Rdy = ar;
    iqIf.Dispatch_SrcB = phys_tag_t'(b); iqIf.Dispatch_SrcB_Rdy = br;
    iqIf.Dispatch_Dest = phys_tag_t'(d); iqIf.Dispatch_Payload = p;
  endtask

  task automatic test_reset();
    setIdle();
    RESET = 0;
    modelReset();
    repeat (2) @(negedge CLK);
    checks++;
    if (iqIf.Count !== '0 || iqIf.Issue_Valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state count=%0d valid=%0b required count=0 valid=0", iqIf.Count, iqIf.Issue_Valid);
    end
    checks++;
    if (iqIf.Issue_SrcA !== '0 || iqIf.Issue_SrcB !== '0 || iqIf.Issue_Dest !== '0 || iqIf.Issue_Payload !== '0) begin
      errors++;
      $display("FAIL reset_fields a=%0d b=%0d d=%0d p=%h required all zero",
               iqIf.Issue_SrcA, iqIf.Issue_SrcB, iqIf.Issue_Dest, iqIf.Issue_Payload);
    end
    RESET = 1;
    @(negedge CLK);
    checks++;
    if (iqIf.Dispatch_Ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got=%0b required=1", iqIf.Dispatch_Ready);
    end
    $display("reset released");
  endtask

  task automatic test_basic();
    setDispatch(3, 1, 5, 1, 9, 32'h1234);
    tick();
    setIdle();
    checks++;
    if (iqIf.Issue_Valid !== 1'b0 || iqIf.Count !== CNT_W'(1)) begin
      errors++;
      $display("FAIL basic_n1 valid=%0b count=%0d required valid=0 count=1", iqIf.Issue_Valid, iqIf.Count);
    end
    tick();
    checks++;
    if (iqIf.Issue_Valid !== 1'b1 || iqIf.Issue_SrcA !== phys_tag_t'(3) || iqIf.Issue_SrcB !== phys_tag_t'(5) ||
        iqIf.Issue_Dest !== phys_tag_t'(9) || iqIf.Issue_Payload !== 32'h1234 || iqIf.Count !== '0) begin
      errors++;
      $display("FAIL basic_issue valid=%0b a=%0d b=%0d d=%0d p=%h count=%0d required 1 3 5 9 1234 0",
               iqIf.Issue_Valid, iqIf.Issue_SrcA, iqIf.Issue_SrcB, iqIf.Issue_Dest, iqIf.Issue_Payload, iqIf.Count);
    end
    $display("basic issue dest=%0d", iqIf.Issue_Dest);
    tick();
  endtask

  task automatic test_wakeup_order();
    setDispatch(7, 0, 8, 1, 10, 32'hA0);
    tick();
    setDispatch(1, 1, 2, 1, 11, 32'hA1);
    tick();
    setIdle();
    checks++;
    if (iqIf.Issue_Valid !== 1'b0) begin
      errors++;
      $display("FAIL wake_early0 valid=%0b required=0", iqIf.Issue_Valid);
    end
    tick();
    checks++;
    if (iqIf.Issue_Valid !== 1'b1 || iqIf.Issue_Dest !== phys_tag_t'(11)) begin
      errors++;
      $display("FAIL wake_younger_first valid=%0b dest=%0d required 1 11", iqIf.Issue_Valid, iqIf.Issue_Dest);
    end
    tick();
    iqIf.Wake_Valid = 1; iqIf.Wake_Tag = phys_tag_t'(7);
    tick();
    setIdle();
    checks++;
    if (iqIf.Issue_Valid !== 1'b0 || iqIf.Count !== CNT_W'(1)) begin
      errors++;
      $display("FAIL wake_not_early valid=%0b count=%0d required 0 1", iqIf.Issue_Valid, iqIf.Count);
    end
    tick();
    checks++;
    if (iqIf.Issue_Valid !== 1'b1 || iqIf.Issue_Dest !== phys_tag_t'(10) || iqIf.Issue_SrcA !== phys_tag_t'(7)) begin
      errors++;
      $display("FAIL wake_issue valid=%0b dest=%0d srcA=%0d required 1 10 7", iqIf.Issue_Valid, iqIf.Issue_Dest, iqIf.Issue_SrcA);
    end
    $display("woken issue dest=%0d", iqIf.Issue_Dest);
    tick();
  endtask

  task automatic test_bypass();
    setDispatch(4, 1, 12, 0, 13, 32'hB0);
    iqIf.Wake_Valid = 1; iqIf.Wake_Tag = phys_tag_t'(12);
    tick();
    setIdle();
    tick();
    checks++;
    if (iqIf.Issue_Valid !== 1'b1 || iqIf.Issue_Dest !== phys_tag_t'(13) || iqIf.Issue_SrcB !== phys_tag_t'(12)) begin
      errors++;
      $display("FAIL bypass valid=%0b dest=%0d srcB=%0d required 1 13 12", iqIf.Issue_Valid, iqIf.Issue_Dest, iqIf.Issue_SrcB);
    end
    $display("bypass issue dest=%0d", iqIf.Issue_Dest);
  endtask

  task automatic test_full();
    iqIf.Issue_Stall = 1;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      setDispatch(20, 0, 21, 1, 16 + i, 32'(i));
      tick();
    end
    checks++;
    if (iqIf.Count !== CNT_W'(IQ_DEPTH) || iqIf.Dispatch_Ready !== 1'b0) begin
      errors++;
      $display("FAIL full count=%0d ready=%0b required 8 0", iqIf.Count, iqIf.Dispatch_Ready);
    end
    setDispatch(1, 1, 1, 1, 63, 32'hDEAD);
    tick();
    checks++;
    if (iqIf.Count !== CNT_W'(IQ_DEPTH)) begin
      errors++;
      $display("FAIL full_refuse count=%0d required=8", iqIf.Count);
    end
    checks++;
    if (iqIf.Issue_Valid !== 1'b1 || iqIf.Issue_Dest !== phys_tag_t'(13)) begin
      errors++;
      $display("FAIL stall_hold valid=%0b dest=%0d required 1 13", iqIf.Issue_Valid, iqIf.Issue_Dest);
    end
    setIdle();
    iqIf.Issue_Stall = 1; iqIf.Wake_Valid = 1; iqIf.Wake_Tag = phys_tag_t'(20);
    tick();
    setIdle();
    for (int k = 0; k < IQ_DEPTH; k++) begin
      tick();
      checks++;
      if (iqIf.Issue_Valid !== 1'b1 || iqIf.Issue_Dest !== phys_tag_t'(16 + k)) begin
        errors++;
        $display("FAIL drain_order k=%0d valid=%0b dest=%0d required 1 %0d", k, iqIf.Issue_Valid, iqIf.Issue_Dest, 16 + k);
      end
      $display("drain issue dest=%0d", iqIf.Issue_Dest);
    end
    tick();
    checks++;
    if (iqIf.Issue_Valid !== 1'b0 || iqIf.Count !== '0) begin
      errors++;
      $display("FAIL drain_empty valid=%0b count=%0d required 0 0", iqIf.Issue_Valid, iqIf.Count);
    end
  endtask

  task automatic test_age_select();
    for (int i = 0; i < 4; i++) begin
      setDispatch(33, 0, 0, 1, 40 + i, 32'(100 + i));
      tick();
    end
    setIdle();
    iqIf.Wake_Valid = 1; iqIf.Wake_Tag = phys_tag_t'(33);
    tick();
    setIdle();
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (iqIf.Issue_Valid !== 1'b1 || iqIf.Issue_Dest !== phys_tag_t'(40 + k) || iqIf.Issue_Payload !== 32'(100 + k)) begin
        errors++;
        $display("FAIL age_select k=%0d valid=%0b dest=%0d required 1 %0d", k, iqIf.Issue_Valid, iqIf.Issue_Dest, 40 + k);
      end
      $display("age issue dest=%0d", iqIf.Issue_Dest);
    end
    tick();
  endtask

  task automatic test_flush();
    setDispatch(1, 1, 2, 1, 50, 32'h50);
    tick();
    setDispatch(51, 0, 2, 1, 51, 32'h51);
    tick();
    iqIf.Issue_Stall = 1;
    for (int i = 0; i < 4; i++) begin
      setDispatch(51, 0, 2, 1, 52 + i, 32'(i));
      tick();
    end
    checks++;
    if (iqIf.Count !== CNT_W'(5) || iqIf.Issue_Valid !== 1'b1 || iqIf.Issue_Dest !== phys_tag_t'(50)) begin
      errors++;
      $display("FAIL flush_setup count=%0d valid=%0b dest=%0d required 5 1 50", iqIf.Count, iqIf.Issue_Valid, iqIf.Issue_Dest);
    end
    setDispatch(3, 1, 3, 1, 60, 32'h60);
    iqIf.Flush = 1;
    tick();
    setIdle();
    checks++;
    if (iqIf.Count !== '0 || iqIf.Issue_Valid !== 1'b0) begin
      errors++;
      $display("FAIL flush count=%0d valid=%0b required 0 0", iqIf.Count, iqIf.Issue_Valid);
    end
    tick();
    checks++;
    if (iqIf.Count !== '0 || iqIf.Issue_Valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop count=%0d valid=%0b required 0 0", iqIf.Count, iqIf.Issue_Valid);
    end
    $display("flush done");
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      setDispatch(45, 0, 1, 1, 30 + i, 32'(i));
      tick();
    end
    setDispatch(1, 1, 1, 1, 34, 32'h34);
    tick();
    setIdle();
    tick();
    checks++;
    if (iqIf.Issue_Valid !== 1'b1 || iqIf.Count !== CNT_W'(3)) begin
      errors++;
      $display("FAIL areset_setup valid=%0b count=%0d required 1 3", iqIf.Issue_Valid, iqIf.Count);
    end
    #2 RESET = 0;
    #1;
    checks++;
    if (iqIf.Count !== '0 || iqIf.Issue_Valid !== 1'b0 || iqIf.Issue_Dest !== '0 || iqIf.Dispatch_Ready !== 1'b1) begin
      errors++;
      $display("FAIL areset count=%0d valid=%0b dest=%0d ready=%0b required 0 0 0 1",
               iqIf.Count, iqIf.Issue_Valid, iqIf.Issue_Dest, iqIf.Dispatch_Ready);
    end
    modelReset();
    #1 RESET = 1;
    @(negedge CLK);
    $display("async reset done");
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      setIdle();
      iqIf.Flush       = ($urandom_range(0, 39) == 0);
      iqIf.Issue_Stall = ($urandom_range(0, 3) == 0);
      iqIf.Wake_Valid  = $urandom_range(0, 1);
      iqIf.Wake_Tag    = phys_tag_t'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 6)
        setDispatch($urandom_range(0, 7), $urandom_range(0, 3) == 0, $urandom_range(0, 7),
                    $urandom_range(0, 1), $urandom_range(0, 63), $urandom);
      tick();
      checks++;
      if (iqIf.Count !== CNT_W'(mQ.size()) || iqIf.Dispatch_Ready !== (mQ.size() < IQ_DEPTH)) begin
        errors++;
        $display("FAIL rand_count cyc=%0d count=%0d ready=%0b required %0d", c, iqIf.Count, iqIf.Dispatch_Ready, mQ.size());
      end
      checks++;
      if (iqIf.Issue_Valid !== mIssValid) begin
        errors++;
        $display("FAIL rand_valid cyc=%0d got=%0b required=%0b", c, iqIf.Issue_Valid, mIssValid);
      end else if (mIssValid) begin
        checks++;
        if (iqIf.Issue_SrcA !== mIssA || iqIf.Issue_SrcB !== mIssB || iqIf.Issue_Dest !== mIssD || iqIf.Issue_Payload !== mIssP) begin
          errors++;
          $display("FAIL rand_bundle cyc=%0d got %0d %0d %0d %h required %0d %0d %0d %h", c,
                   iqIf.Issue_SrcA, iqIf.Issue_SrcB, iqIf.Issue_Dest, iqIf.Issue_Payload, mIssA, mIssB, mIssD, mIssP);
        end
        $display("rand issue cyc=%0d a=%0d b=%0d d=%0d", c, iqIf.Issue_SrcA, iqIf.Issue_SrcB, iqIf.Issue_Dest);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup_order();
    test_bypass();
    test_full();
    test_age_select();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
